execute_stage_md: RTL and testbench
===================================

# execute_stage_md

Parametrised execute stage for the 5-stage RISC-V pipeline, successor to the single-cycle execute stage. It adds XLEN parametrisation, full RV32I branch conditions, JALR target generation, flush/stall handshakes with the hazard unit, and an iterative RV32M multiply/divide unit that stalls the front of the pipeline. It sits between the D/E and E/M pipeline registers and owns the E/M register.

## Interface
- XLEN, 32, datapath width (≥8, power of 2)
- clk  in  1  clock
- srst  in  1  reset, synchronous, active-high
- pc_e, pc_plus4_e  in  XLEN  PC and PC+4 of the E instruction
- rs1_e, rs2_e, rd_e  in  5  register indices (rs1/rs2 pass to the hazard unit only)
- rd1_e, rd2_e, imm_ext_e  in  XLEN  register operands and extended immediate
- result_w, alu_result_m  in  XLEN  forwarding sources from W and M
- forward_a_e, forward_b_e  in  2  forward select: 00 rd, 01 result_w, 10 alu_result_m
- reg_write_e, mem_write_e, jump_e, jalr_e, branch_e, alu_src_e  in  1  controls
- result_src_e  in  2  result select, passed to M
- alu_control_e  in  4  riscv_pkg::alu_op_e
- branch_cond_e  in  3  funct3 of branch (BEQ/BNE/BLT/BGE/BLTU/BGEU)
- md_en_e  in  1  E holds an M-extension op
- md_op_e  in  3  funct3 of M op (MUL…REMU)
- flush_e  in  1  squash the E instruction
- stall_e  out  1  hold F/D/E; a multi-cycle op is in progress
- res_src_e  out  1  result_src_e[0], for load-use detection
- pc_src_e  out  1  redirect fetch
- pc_target_e  out  XLEN  redirect target
- pc_plus4_m, alu_result_m_q, write_data_m  out  XLEN  E/M register
- rd_m  out  5; result_src_m  out  2; mem_write_m, reg_write_m  out  1  E/M register

## Operation
- Operand muxes: srcA = fwd(rd1_e, forward_a_e); write_data_e = fwd(rd2_e, forward_b_e); srcB = alu_src_e ? imm_ext_e : write_data_e. Select 11 behaves as 00.
- ALU ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU. Shift amount is srcB[$clog2(XLEN)-1:0].
- Branch compare uses srcA and write_data_e, signed or unsigned per branch_cond_e. Reserved codes 010/011 mean not taken.
- pc_src_e = jump_e | (branch_e & cond_true) & ~flush_e.
- pc_target_e = jalr_e ? (alu_result & ~1) : pc_e + imm_ext_e, computed modulo 2^XLEN.
- Muldiv FSM: IDLE → BUSY → DONE → IDLE.
  - IDLE, md_en_e & ~flush_e: latch operands and op, counter = 0, go BUSY.
  - BUSY: one radix-2 iteration per cycle. After XLEN iterations, go DONE.
  - DONE: result is valid and is captured into the E/M register, then IDLE.
- stall_e = md_en_e & (state != DONE) & ~flush_e.
- Signed ops work on magnitudes, with the sign fixed up in DONE. MULH/MULHSU/MULHU return the upper XLEN bits; MUL returns the lower XLEN bits.
- Divide by zero: quotient = all ones, remainder = dividend.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- E/M register, when not srst:
  - If flush_e or stall_e: insert a bubble (reg_write_m = 0, mem_write_m = 0, rd_m = 0, other fields don't-care, driven 0).
  - Otherwise load the E values. alu_result_m_q takes the muldiv result when md_en_e, else the ALU result.
- flush_e in any FSM state: return to IDLE next cycle and discard the partial result.

## Timing
- Reset: all E/M outputs 0, FSM IDLE, counter 0. stall_e and pc_src_e are forced 0 while srst is high.
- Non-M instructions: combinational through E, registered at the next edge. Latency 1.
- M op entering E in cycle t:
  - stall_e = 1 for cycles t … t+XLEN.
  - DONE in cycle t+XLEN+1, with stall_e = 0.
  - The result reaches the E/M register at the end of t+XLEN+1. Occupancy is XLEN+2 cycles.
  - Bubbles go to M for cycles t … t+XLEN.
- Back-to-back M ops: the second starts from IDLE in the cycle after DONE; there is no overlap.
- Operands are latched at IDLE→BUSY. Forwarding changes during BUSY are ignored.
- srst mid-operation aborts to IDLE at that edge.

## Structure
- riscv_pkg holds alu_op_e, branch_cond_e, md_op_e, and the forward select constants.
- Sub-module muldiv_iter #(XLEN) contains the FSM, counter, shift-add multiplier and restoring divider. Its handshake is start/busy/done/result.
- The ALU, operand muxes, branch compare and E/M register stay in the top module.

## Test plan
- ADD, forward_a_e=10, alu_result_m=5, imm=3, alu_src=1 → alu_result_m_q=8 after one edge.
- BLT with srcA=-1, srcB=1 → pc_src_e=1. BLTU with the same operands → 0. pc_target = pc_e + imm.
- JALR with srcA=0x1001, imm=0 → pc_target_e=0x1000, pc_src_e=1.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → stall_e high 33 cycles, result 0xFFFFFFFE. Bubbles in M meanwhile.
- DIV 0x80000000 / -1 → 0x80000000. REMU x/0 → x. DIV 7/0 → 0xFFFFFFFF.
- flush_e during BUSY cycle 10 → IDLE next cycle, stall_e=0, bubble in M. srst mid-op → all outputs 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the RISC-V execute stage.
//   alu_op_e      - ALU operation carried on alu_control_e
//   branch_cond_e - branch funct3 codes (010/011 are reserved, never taken)
//   md_op_e       - M-extension funct3 codes
//   md_state_e    - iterative multiply/divide FSM states
//   FWD_*         - forwarding mux selects (11 falls back to the register value)
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } branch_cond_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [1:0] FWD_RD = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/execute_stage_md_if.sv
// execute_stage_md_if: the E/M pipeline register bundle.
//   master - driven by the execute stage (owner of the E/M register)
//   slave  - consumed by the memory stage
interface execute_stage_md_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_plus4_m;
    logic [XLEN-1:0] alu_result_m_q;
    logic [XLEN-1:0] write_data_m;
    logic [4:0]      rd_m;
    logic [1:0]      result_src_m;
    logic            mem_write_m;
    logic            reg_write_m;

    modport master (
        output pc_plus4_m, alu_result_m_q, write_data_m,
               rd_m, result_src_m, mem_write_m, reg_write_m
    );

    modport slave (
        input  pc_plus4_m, alu_result_m_q, write_data_m,
               rd_m, result_src_m, mem_write_m, reg_write_m
    );
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M-style multiply/divide, one radix-2 step per cycle.
//   clk, srst     - clock, synchronous active-high reset
//   start         - begin an operation (sampled only in IDLE)
//   flush         - abandon any operation, back to IDLE next cycle
//   op            - M-extension funct3
//   a, b          - operands (rs1, rs2), captured at IDLE->BUSY
//   busy          - XLEN iterations in progress
//   done          - result valid this cycle (single-cycle DONE state)
//   result        - signed-corrected result, meaningful while done
// Operands are converted to magnitudes on entry; the sign is restored
// combinationally from the registered accumulator while in DONE.
module muldiv_iter
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    md_state_e         state_reg, state_next;
    logic [CW-1:0]     count_reg, count_next;
    // Multiply: {product_hi, multiplier shifting out}. Divide: {remainder, quotient}.
    logic [2*XLEN-1:0] acc_reg, acc_next;
    logic [XLEN-1:0]   opb_reg, opb_next;        // multiplicand / divisor magnitude
    logic [XLEN-1:0]   dividend_reg, dividend_next;
    md_op_e            op_reg, op_next;
    logic              neg_res_reg, neg_res_next;
    logic              neg_rem_reg, neg_rem_next;
    logic              div_zero_reg, div_zero_next;

    md_op_e            op_in;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              is_div;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     div_shift, div_diff;
    logic [2*XLEN-1:0] div_step;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    assign op_in = md_op_e'(op);

    always_comb begin
        a_signed = op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        b_signed = op_in inside {MD_MULH, MD_DIV, MD_REM};
        a_neg    = a_signed & a[XLEN-1];
        b_neg    = b_signed & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
    end

    assign is_div = op_reg inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};

    // Shift-add: add the multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + ({1'b0, opb_reg} & {(XLEN+1){acc_reg[0]}});
    assign mul_step = {mul_sum, acc_reg[XLEN-1:1]};

    // Restoring division: bring the next dividend bit into the remainder and
    // keep the subtraction only if it did not go negative.
    assign div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb_reg};
    assign div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  acc_reg[XLEN-2:0], 1'b1};

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        acc_next      = acc_reg;
        opb_next      = opb_reg;
        dividend_next = dividend_reg;
        op_next       = op_reg;
        neg_res_next  = neg_res_reg;
        neg_rem_next  = neg_rem_reg;
        div_zero_next = div_zero_reg;
        case (state_reg)
            MD_IDLE: begin
                if (start) begin
                    state_next    = MD_BUSY;
                    count_next    = '0;
                    acc_next      = {{XLEN{1'b0}}, a_mag};
                    opb_next      = b_mag;
                    dividend_next = a;
                    op_next       = op_in;
                    neg_res_next  = a_neg ^ b_neg;
                    neg_rem_next  = a_neg;
                    div_zero_next = (b == '0);
                end
            end
            MD_BUSY: begin
                acc_next   = is_div ? div_step : mul_step;
                count_next = count_reg + 1'b1;
                if (count_reg == CW'(XLEN - 1)) begin
                    state_next = MD_DONE;
                end
            end
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
        if (flush) begin
            state_next = MD_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg    <= MD_IDLE;
            count_reg    <= '0;
            acc_reg      <= '0;
            opb_reg      <= '0;
            dividend_reg <= '0;
            op_reg       <= MD_MUL;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            acc_reg      <= acc_next;
            opb_reg      <= opb_next;
            dividend_reg <= dividend_next;
            op_reg       <= op_next;
            neg_res_reg  <= neg_res_next;
            neg_rem_reg  <= neg_rem_next;
            div_zero_reg <= div_zero_next;
        end
    end

    // Sign restoration. Divide-by-zero bypasses it; MIN / -1 needs no special
    // case because |MIN| / 1 already yields the MIN bit pattern with a zero remainder.
    assign prod_fix = neg_res_reg ? -acc_reg : acc_reg;
    assign quo_fix  = neg_res_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    assign rem_fix  = neg_rem_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];

    always_comb begin
        result = '0;
        case (op_reg)
            MD_MUL:                       result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              result = div_zero_reg ? {XLEN{1'b1}} : quo_fix;
            MD_REM, MD_REMU:              result = div_zero_reg ? dividend_reg : rem_fix;
            default:                      result = '0;
        endcase
    end

    assign busy = (state_reg == MD_BUSY);
    assign done = (state_reg == MD_DONE);

endmodule

// File: rtl/execute_stage_md.sv
// execute_stage_md: pipeline execute stage with iterative M-extension unit.
//   clk, srst                - clock, synchronous active-high reset
//   pc_e, pc_plus4_e         - PC / PC+4 of the E instruction
//   rs1_e, rs2_e             - source indices (hazard unit only, unused here)
//   rd_e                     - destination index
//   rd1_e, rd2_e, imm_ext_e  - register operands, extended immediate
//   result_w, alu_result_m   - forwarding sources
//   forward_a_e/forward_b_e  - forward selects
//   *_e controls             - reg/mem write, jump, jalr, branch, alu_src, result_src
//   alu_control_e            - ALU operation
//   branch_cond_e            - branch funct3
//   md_en_e, md_op_e         - M-extension op present / funct3
//   flush_e                  - squash the E instruction
//   stall_e                  - hold F/D/E while a multiply/divide runs
//   res_src_e                - result_src_e[0] for load-use detection
//   pc_src_e, pc_target_e    - fetch redirect
//   em                       - E/M pipeline register (master side)
// XLEN must be a power of two and at least 8.
module execute_stage_md #(
    parameter int XLEN = 32
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic [XLEN-1:0]        pc_e,
    input  logic [XLEN-1:0]        pc_plus4_e,
    input  logic [4:0]             rs1_e,
    input  logic [4:0]             rs2_e,
    input  logic [4:0]             rd_e,
    input  logic [XLEN-1:0]        rd1_e,
    input  logic [XLEN-1:0]        rd2_e,
    input  logic [XLEN-1:0]        imm_ext_e,
    input  logic [XLEN-1:0]        result_w,
    input  logic [XLEN-1:0]        alu_result_m,
    input  logic [1:0]             forward_a_e,
    input  logic [1:0]             forward_b_e,
    input  logic                   reg_write_e,
    input  logic                   mem_write_e,
    input  logic                   jump_e,
    input  logic                   jalr_e,
    input  logic                   branch_e,
    input  logic                   alu_src_e,
    input  logic [1:0]             result_src_e,
    input  riscv_pkg::alu_op_e     alu_control_e,
    input  logic [2:0]             branch_cond_e,
    input  logic                   md_en_e,
    input  logic [2:0]             md_op_e,
    input  logic                   flush_e,
    output logic                   stall_e,
    output logic                   res_src_e,
    output logic                   pc_src_e,
    output logic [XLEN-1:0]        pc_target_e,
    execute_stage_md_if.master     em
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] src_a, src_b, write_data_e;
    logic [XLEN-1:0] alu_result;
    logic [SHW-1:0]  shamt;
    logic            cond_true;
    logic            md_start, md_busy, md_done;
    logic [XLEN-1:0] md_result;
    logic            unused_ok;

    // Forwarding muxes; select 11 falls through to the register value.
    always_comb begin
        case (forward_a_e)
            riscv_pkg::FWD_W: src_a = result_w;
            riscv_pkg::FWD_M: src_a = alu_result_m;
            default:          src_a = rd1_e;
        endcase
        case (forward_b_e)
            riscv_pkg::FWD_W: write_data_e = result_w;
            riscv_pkg::FWD_M: write_data_e = alu_result_m;
            default:          write_data_e = rd2_e;
        endcase
    end

    assign src_b = alu_src_e ? imm_ext_e : write_data_e;
    assign shamt = src_b[SHW-1:0];

    always_comb begin
        alu_result = '0;
        case (alu_control_e)
            riscv_pkg::ALU_ADD:  alu_result = src_a + src_b;
            riscv_pkg::ALU_SUB:  alu_result = src_a - src_b;
            riscv_pkg::ALU_AND:  alu_result = src_a & src_b;
            riscv_pkg::ALU_OR:   alu_result = src_a | src_b;
            riscv_pkg::ALU_XOR:  alu_result = src_a ^ src_b;
            riscv_pkg::ALU_SLL:  alu_result = src_a << shamt;
            riscv_pkg::ALU_SRL:  alu_result = src_a >> shamt;
            riscv_pkg::ALU_SRA:  alu_result = $signed(src_a) >>> shamt;
            riscv_pkg::ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            riscv_pkg::ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
            default:             alu_result = '0;
        endcase
    end

    // Branches always compare the two register operands, never the immediate.
    always_comb begin
        cond_true = 1'b0;
        case (branch_cond_e)
            riscv_pkg::BR_EQ:  cond_true = (src_a == write_data_e);
            riscv_pkg::BR_NE:  cond_true = (src_a != write_data_e);
            riscv_pkg::BR_LT:  cond_true = ($signed(src_a) <  $signed(write_data_e));
            riscv_pkg::BR_GE:  cond_true = ($signed(src_a) >= $signed(write_data_e));
            riscv_pkg::BR_LTU: cond_true = (src_a <  write_data_e);
            riscv_pkg::BR_GEU: cond_true = (src_a >= write_data_e);
            default:           cond_true = 1'b0;
        endcase
    end

    // A squashed instruction must never redirect fetch, whether jump or branch.
    assign pc_src_e    = ~srst & ~flush_e & (jump_e | (branch_e & cond_true));
    assign pc_target_e = jalr_e ? (alu_result & {{(XLEN-1){1'b1}}, 1'b0}) : (pc_e + imm_ext_e);
    assign res_src_e   = result_src_e[0];

    assign md_start = md_en_e & ~flush_e;
    assign stall_e  = ~srst & md_en_e & ~md_done & ~flush_e;

    muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk    (clk),
        .srst   (srst),
        .start  (md_start),
        .flush  (flush_e),
        .op     (md_op_e),
        .a      (src_a),
        .b      (write_data_e),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // E/M register: bubbles while stalled or flushed.
    always_ff @(posedge clk) begin
        if (srst || flush_e || stall_e) begin
            em.pc_plus4_m     <= '0;
            em.alu_result_m_q <= '0;
            em.write_data_m   <= '0;
            em.rd_m           <= '0;
            em.result_src_m   <= '0;
            em.mem_write_m    <= 1'b0;
            em.reg_write_m    <= 1'b0;
        end else begin
            em.pc_plus4_m     <= pc_plus4_e;
            em.alu_result_m_q <= md_en_e ? md_result : alu_result;
            em.write_data_m   <= write_data_e;
            em.rd_m           <= rd_e;
            em.result_src_m   <= result_src_e;
            em.mem_write_m    <= mem_write_e;
            em.reg_write_m    <= reg_write_e;
        end
    end

    assign unused_ok = ^{rs1_e, rs2_e, md_busy};

endmodule

// File: tb/tb_execute_stage_md.sv
module tb_execute_stage_md;
    localparam int XLEN = 32;

    logic                 clk = 1'b0;
    logic                 srst;
    logic [XLEN-1:0]      pc_e, pc_plus4_e, rd1_e, rd2_e, imm_ext_e, result_w, alu_result_m;
    logic [4:0]           rs1_e, rs2_e, rd_e;
    logic [1:0]           forward_a_e, forward_b_e, result_src_e;
    logic                 reg_write_e, mem_write_e, jump_e, jalr_e, branch_e, alu_src_e;
    riscv_pkg::alu_op_e   alu_control_e;
    logic [2:0]           branch_cond_e, md_op_e;
    logic                 md_en_e, flush_e;
    logic                 stall_e, res_src_e, pc_src_e;
    logic [XLEN-1:0]      pc_target_e;

    execute_stage_md_if #(.XLEN(XLEN)) em_bus ();

    execute_stage_md #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .srst          (srst),
        .pc_e          (pc_e),
        .pc_plus4_e    (pc_plus4_e),
        .rs1_e         (rs1_e),
        .rs2_e         (rs2_e),
        .rd_e          (rd_e),
        .rd1_e         (rd1_e),
        .rd2_e         (rd2_e),
        .imm_ext_e     (imm_ext_e),
        .result_w      (result_w),
        .alu_result_m  (alu_result_m),
        .forward_a_e   (forward_a_e),
        .forward_b_e   (forward_b_e),
        .reg_write_e   (reg_write_e),
        .mem_write_e   (mem_write_e),
        .jump_e        (jump_e),
        .jalr_e        (jalr_e),
        .branch_e      (branch_e),
        .alu_src_e     (alu_src_e),
        .result_src_e  (result_src_e),
        .alu_control_e (alu_control_e),
        .branch_cond_e (branch_cond_e),
        .md_en_e       (md_en_e),
        .md_op_e       (md_op_e),
        .flush_e       (flush_e),
        .stall_e       (stall_e),
        .res_src_e     (res_src_e),
        .pc_src_e      (pc_src_e),
        .pc_target_e   (pc_target_e),
        .em            (em_bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [1:0]  rs;
        logic        mw;
        logic        rw;
    } em_t;

    em_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic em_t exp_instr(input logic [31:0] alu, input logic [31:0] wd);
        em_t e;
        e.pc4 = pc_plus4_e;
        e.alu = alu;
        e.wd  = wd;
        e.rd  = rd_e;
        e.rs  = result_src_e;
        e.mw  = mem_write_e;
        e.rw  = reg_write_e;
        return e;
    endfunction

    // Advance one clock and compare the E/M register with the oldest expectation.
    task automatic tick(input string tag);
        em_t e;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val({tag, ".alu"}, em_bus.alu_result_m_q, e.alu);
        check_val({tag, ".wd"},  em_bus.write_data_m,   e.wd);
        check_val({tag, ".pc4"}, em_bus.pc_plus4_m,     e.pc4);
        check_val({tag, ".rd"},  em_bus.rd_m,           e.rd);
        check_val({tag, ".rs"},  em_bus.result_src_m,   e.rs);
        check_val({tag, ".mw"},  em_bus.mem_write_m,    e.mw);
        check_val({tag, ".rw"},  em_bus.reg_write_m,    e.rw);
        $display("[%0t] %-12s alu=%08h rd=%0d rw=%b stall=%b", $time, tag,
                 em_bus.alu_result_m_q, em_bus.rd_m, em_bus.reg_write_m, stall_e);
    endtask

    task automatic clear_inputs();
        pc_e = '0; pc_plus4_e = '0; rd1_e = '0; rd2_e = '0; imm_ext_e = '0;
        result_w = '0; alu_result_m = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
        forward_a_e = 2'b00; forward_b_e = 2'b00; result_src_e = 2'b00;
        reg_write_e = 1'b0; mem_write_e = 1'b0; jump_e = 1'b0; jalr_e = 1'b0;
        branch_e = 1'b0; alu_src_e = 1'b0; alu_control_e = riscv_pkg::ALU_ADD;
        branch_cond_e = 3'b000; md_en_e = 1'b0; md_op_e = 3'b000; flush_e = 1'b0;
    endtask

    task automatic run_alu(input string tag, input riscv_pkg::alu_op_e op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        clear_inputs();
        alu_control_e = op; rd1_e = a; rd2_e = b; rd_e = 5'd9; reg_write_e = 1'b1;
        pc_plus4_e = 32'h0000_0208;
        sb_q.push_back(exp_instr(exp, b));
        tick(tag);
    endtask

    task automatic run_branch(input string tag, input logic [2:0] cond,
                              input logic [31:0] a, input logic [31:0] b, input logic taken);
        clear_inputs();
        branch_e = 1'b1; branch_cond_e = cond; rd1_e = a; rd2_e = b;
        alu_control_e = riscv_pkg::ALU_SUB; pc_e = 32'h0000_0200; imm_ext_e = 32'h0000_0040;
        pc_plus4_e = 32'h0000_0204;
        #1;
        check_val({tag, ".pc_src"}, pc_src_e, taken);
        check_val({tag, ".target"}, pc_target_e, 32'h0000_0240);
        sb_q.push_back(exp_instr(a - b, b));
        tick(tag);
    endtask

    // One M op: bubbles while stalled, then the result lands in E/M.
    task automatic run_md(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        clear_inputs();
        md_en_e = 1'b1; md_op_e = op; rd1_e = a; rd2_e = b; rd_e = 5'd7;
        reg_write_e = 1'b1; pc_plus4_e = 32'h0000_0400;
        n = 0;
        #1;
        while (stall_e === 1'b1 && n < 100) begin
            sb_q.push_back('0);
            tick({tag, "_bub"});
            n++;
        end
        check_val({tag, ".stall_cycles"}, n, 33);
        sb_q.push_back(exp_instr(exp, b));
        tick(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset: even with a jump and an M op on the inputs, nothing escapes.
        clear_inputs();
        srst = 1'b1; jump_e = 1'b1; md_en_e = 1'b1; rd_e = 5'd3; reg_write_e = 1'b1;
        #1;
        check_val("rst.stall", stall_e, 0);
        check_val("rst.pc_src", pc_src_e, 0);
        sb_q.push_back('0); tick("reset0");
        sb_q.push_back('0); tick("reset1");
        srst = 1'b0;

        // ADD with forwarding from M and immediate source.
        clear_inputs();
        forward_a_e = 2'b10; alu_result_m = 32'd5; rd1_e = 32'hDEAD; imm_ext_e = 32'd3;
        alu_src_e = 1'b1; rd2_e = 32'h77; rd_e = 5'd5; reg_write_e = 1'b1;
        result_src_e = 2'b01; mem_write_e = 1'b1; pc_plus4_e = 32'h104;
        #1;
        check_val("res_src", res_src_e, 1);
        sb_q.push_back(exp_instr(32'd8, 32'h77));
        tick("add_fwd_m");

        // Forward B from W, and select 11 behaving as the register value.
        clear_inputs();
        forward_b_e = 2'b01; result_w = 32'h55; rd2_e = 32'h99; rd1_e = 32'h1; rd_e = 5'd2;
        reg_write_e = 1'b1;
        sb_q.push_back(exp_instr(32'h56, 32'h55));
        tick("add_fwd_w");
        clear_inputs();
        forward_a_e = 2'b11; forward_b_e = 2'b11; rd1_e = 32'h10; rd2_e = 32'h20;
        result_w = 32'hAAAA; alu_result_m = 32'hBBBB; rd_e = 5'd4; reg_write_e = 1'b1;
        sb_q.push_back(exp_instr(32'h30, 32'h20));
        tick("fwd_11");

        run_alu("sub",      riscv_pkg::ALU_SUB,  32'd10,        32'd3,  32'd7);
        run_alu("add_wrap", riscv_pkg::ALU_ADD,  32'hFFFF_FFFF, 32'd1,  32'h0);
        run_alu("and",      riscv_pkg::ALU_AND,  32'hF0F0,      32'hFF00, 32'hF000);
        run_alu("or",       riscv_pkg::ALU_OR,   32'hF0F0,      32'hFF00, 32'hFFF0);
        run_alu("xor",      riscv_pkg::ALU_XOR,  32'hF0F0,      32'hFF00, 32'h0FF0);
        run_alu("sll31",    riscv_pkg::ALU_SLL,  32'd1,         32'd31, 32'h8000_0000);
        run_alu("sll_wrap", riscv_pkg::ALU_SLL,  32'd1,         32'h21, 32'h2);
        run_alu("srl",      riscv_pkg::ALU_SRL,  32'h8000_0000, 32'd4,  32'h0800_0000);
        run_alu("sra",      riscv_pkg::ALU_SRA,  32'h8000_0000, 32'd4,  32'hF800_0000);
        run_alu("slt",      riscv_pkg::ALU_SLT,  32'hFFFF_FFFF, 32'd1,  32'd1);
        run_alu("sltu",     riscv_pkg::ALU_SLTU, 32'hFFFF_FFFF, 32'd1,  32'd0);

        run_branch("blt",   3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1);
        run_branch("bltu",  3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_branch("bge",   3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_branch("bgeu",  3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1);
        run_branch("beq",   3'b000, 32'd5, 32'd5, 1'b1);
        run_branch("bne",   3'b001, 32'd5, 32'd5, 1'b0);
        run_branch("rsv010", 3'b010, 32'd5, 32'd5, 1'b0);
        run_branch("rsv011", 3'b011, 32'd5, 32'd6, 1'b0);

        // Taken branch that is flushed: no redirect, bubble in M.
        clear_inputs();
        branch_e = 1'b1; branch_cond_e = 3'b000; rd1_e = 32'd1; rd2_e = 32'd1;
        reg_write_e = 1'b1; rd_e = 5'd8; flush_e = 1'b1;
        #1;
        check_val("flush_br.pc_src", pc_src_e, 0);
        sb_q.push_back('0);
        tick("flush_br");

        // JALR clears bit 0 of the target.
        clear_inputs();
        jump_e = 1'b1; jalr_e = 1'b1; rd1_e = 32'h1001; imm_ext_e = 32'h0; alu_src_e = 1'b1;
        rd_e = 5'd1; reg_write_e = 1'b1; result_src_e = 2'b10; pc_plus4_e = 32'h304;
        pc_e = 32'h300;
        #1;
        check_val("jalr.pc_src", pc_src_e, 1);
        check_val("jalr.target", pc_target_e, 32'h1000);
        sb_q.push_back(exp_instr(32'h1001, 32'h0));
        tick("jalr");

        // M ops, back to back.
        run_md("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_md("mul_neg", 3'b000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1);
        run_md("mulh",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        run_md("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md("mul_lo",  3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0);
        run_md("mulhu_1", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'h1);
        run_md("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_md("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_md("remu_z",  3'b111, 32'h0000_1234, 32'h0,         32'h0000_1234);
        run_md("div_z",   3'b100, 32'd7,         32'h0,         32'hFFFF_FFFF);
        run_md("rem_z",   3'b110, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB);
        run_md("divu",    3'b101, 32'd100,       32'd7,         32'd14);
        run_md("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run_md("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);

        // Plain instruction straight after an M op: latency 1.
        run_alu("post_md", riscv_pkg::ALU_ADD, 32'd40, 32'd2, 32'd42);

        // Flush in the middle of BUSY, then a fresh op must take the full time.
        clear_inputs();
        md_en_e = 1'b1; md_op_e = 3'b000; rd1_e = 32'd3; rd2_e = 32'd4; rd_e = 5'd6;
        reg_write_e = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sb_q.push_back('0);
            tick("flush_bub");
        end
        flush_e = 1'b1;
        #1;
        check_val("flush_md.stall", stall_e, 0);
        sb_q.push_back('0);
        tick("flush_md");
        run_md("after_flush", 3'b101, 32'd100, 32'd7, 32'd14);

        // Reset in the middle of an operation.
        clear_inputs();
        md_en_e = 1'b1; md_op_e = 3'b000; rd1_e = 32'd9; rd2_e = 32'd9; rd_e = 5'd6;
        reg_write_e = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back('0);
            tick("srst_bub");
        end
        srst = 1'b1; jump_e = 1'b1;
        #1;
        check_val("srst_mid.stall", stall_e, 0);
        check_val("srst_mid.pc_src", pc_src_e, 0);
        sb_q.push_back('0);
        tick("srst_mid");
        srst = 1'b0;
        run_md("after_srst", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Flushed plain instruction becomes a bubble.
        clear_inputs();
        rd1_e = 32'd1; rd2_e = 32'd1; rd_e = 5'd10; reg_write_e = 1'b1; mem_write_e = 1'b1;
        flush_e = 1'b1;
        sb_q.push_back('0);
        tick("flush_alu");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
